// File: rtl/wb_stage.sv
// Write-back stage: commits register-file writes, owns the CP0 subset and
// turns exceptions, ERET and TLBR/TLBWI into one-cycle flush/refetch pulses.
module wb_stage #(
  parameter int          MS_TO_WS_BUS_WD = 131,
  parameter logic [31:0] EX_VECTOR       = 32'hBFC0_0380,
  parameter logic [31:0] REFILL_VECTOR   = 32'hBFC0_0200
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       ws_allowin,
  input  logic                       ms_to_ws_valid,
  input  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic [5:0]                 ext_int,
  output logic                       rf_we,
  output logic [4:0]                 rf_waddr,
  output logic [31:0]                rf_wdata,
  output logic                       ms_ex,
  output logic [31:0]                ex_target,
  output logic                       ms_cancel_in,
  output logic [31:0]                refetch_pc,
  output logic                       tlbwi_we,
  output logic                       tlbr_re,
  output logic                       int_pending,
  output logic [31:0]                debug_wb_pc,
  output logic [3:0]                 debug_wb_rf_wen,
  output logic [4:0]                 debug_wb_rf_wnum,
  output logic [31:0]                debug_wb_rf_wdata
);

  localparam logic [7:0] CP0_BADVADDR = 8'h40;
  localparam logic [7:0] CP0_COUNT    = 8'h48;
  localparam logic [7:0] CP0_COMPARE  = 8'h58;
  localparam logic [7:0] CP0_STATUS   = 8'h60;
  localparam logic [7:0] CP0_CAUSE    = 8'h68;
  localparam logic [7:0] CP0_EPC      = 8'h70;

  logic                       r_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] r_bus;

  logic [7:0]  r_status_im;
  logic        r_status_exl;
  logic        r_status_ie;
  logic        r_cause_bd;
  logic        r_cause_ti;
  logic [1:0]  r_cause_ip_sw;
  logic [4:0]  r_cause_exccode;
  logic [31:0] r_epc;
  logic [31:0] r_badvaddr;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_tick;

  logic        w_tlb_refill, w_tlbr, w_tlbwi, w_eret_f, w_bd, w_has_exc;
  logic        w_cp0_op, w_cp0_we, w_gr_we;
  logic [31:0] w_badvaddr, w_result, w_pc;
  logic [4:0]  w_exccode, w_dest;
  logic [7:0]  w_cp0_addr;
  logic        w_unused_fields;

  assign w_tlb_refill = r_bus[130];
  assign w_tlbr       = r_bus[123];
  assign w_tlbwi      = r_bus[122];
  assign w_eret_f     = r_bus[121];
  assign w_badvaddr   = r_bus[120:89];
  assign w_bd         = r_bus[88];
  assign w_has_exc    = r_bus[87];
  assign w_exccode    = r_bus[86:82];
  assign w_cp0_op     = r_bus[81];
  assign w_cp0_we     = r_bus[80];
  assign w_cp0_addr   = r_bus[79:72];
  assign w_gr_we      = r_bus[69];
  assign w_dest       = r_bus[68:64];
  assign w_result     = r_bus[63:32];
  assign w_pc         = r_bus[31:0];
  // TLBP index/found and the load offset are consumed elsewhere in the pipe.
  assign w_unused_fields = ^{r_bus[129:124], r_bus[71:70]};

  logic w_exc, w_eret, w_mtc0, w_tlb_op, w_badv_we;
  logic [7:0]  w_cause_ip;
  logic [31:0] w_status, w_cause, w_cp0_rdata;

  assign w_exc     = r_ws_valid & w_has_exc;
  assign w_eret    = r_ws_valid & w_eret_f & ~w_has_exc;
  assign w_mtc0    = r_ws_valid & w_cp0_we & ~w_has_exc;
  assign w_tlb_op  = r_ws_valid & ~w_has_exc & (w_tlbwi | w_tlbr);
  assign w_badv_we = (w_exccode == 5'd2) | (w_exccode == 5'd3) |
                     (w_exccode == 5'd4) | (w_exccode == 5'd5);

  // Hardware IP bits track ext_int live; IP7 also carries the timer.
  assign w_cause_ip = {ext_int[5] | r_cause_ti, ext_int[4:0], r_cause_ip_sw};
  assign w_status   = {9'd0, 1'b1, 6'd0, r_status_im, 6'd0, r_status_exl, r_status_ie};
  assign w_cause    = {r_cause_bd, r_cause_ti, 14'd0, w_cause_ip, 1'b0, r_cause_exccode, 2'b00};

  // MFC0 read mux
  always_comb begin
    w_cp0_rdata = 32'd0;
    case (w_cp0_addr)
      CP0_BADVADDR: w_cp0_rdata = r_badvaddr;
      CP0_COUNT:    w_cp0_rdata = r_count;
      CP0_COMPARE:  w_cp0_rdata = r_compare;
      CP0_STATUS:   w_cp0_rdata = w_status;
      CP0_CAUSE:    w_cp0_rdata = w_cause;
      CP0_EPC:      w_cp0_rdata = r_epc;
      default:      w_cp0_rdata = 32'd0;
    endcase
  end

  // Stage valid and latched memory-stage bus
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ws_valid <= 1'b0;
      r_bus      <= '0;
    end else begin
      r_ws_valid <= (ms_ex | ms_cancel_in) ? 1'b0 : ms_to_ws_valid;
      if (ms_to_ws_valid & ws_allowin) begin
        r_bus <= ms_to_ws_bus;
      end
    end
  end

  // CP0 register file: timer, exception entry, ERET and MTC0 updates
  always_ff @(posedge clk) begin
    if (reset) begin
      r_status_im     <= 8'd0;
      r_status_exl    <= 1'b0;
      r_status_ie     <= 1'b0;
      r_cause_bd      <= 1'b0;
      r_cause_ti      <= 1'b0;
      r_cause_ip_sw   <= 2'd0;
      r_cause_exccode <= 5'd0;
      r_epc           <= 32'd0;
      r_badvaddr      <= 32'd0;
      r_count         <= 32'd0;
      r_compare       <= 32'd0;
      r_tick          <= 1'b0;
    end else begin
      r_tick <= ~r_tick;
      if (w_mtc0 && w_cp0_addr == CP0_COUNT) begin
        r_count <= w_result;
      end else if (r_tick) begin
        r_count <= r_count + 32'd1;
      end

      if (w_mtc0 && w_cp0_addr == CP0_COMPARE) begin
        r_compare  <= w_result;
        r_cause_ti <= 1'b0;
      end else if (r_count == r_compare) begin
        r_cause_ti <= 1'b1;
      end

      // A nested exception (EXL already set) keeps the original EPC/BD.
      if (w_exc) begin
        r_status_exl    <= 1'b1;
        r_cause_exccode <= w_exccode;
        if (!r_status_exl) begin
          r_epc      <= w_bd ? (w_pc - 32'd4) : w_pc;
          r_cause_bd <= w_bd;
        end
        if (w_badv_we) begin
          r_badvaddr <= w_badvaddr;
        end
      end else if (w_eret) begin
        r_status_exl <= 1'b0;
      end else if (w_mtc0 && w_cp0_addr == CP0_STATUS) begin
        r_status_im  <= w_result[15:8];
        r_status_exl <= w_result[1];
        r_status_ie  <= w_result[0];
      end else if (w_mtc0 && w_cp0_addr == CP0_CAUSE) begin
        r_cause_ip_sw <= w_result[9:8];
      end
    end
  end

  assign ws_allowin   = 1'b1;
  assign rf_we        = r_ws_valid & w_gr_we & ~w_has_exc;
  assign rf_waddr     = w_dest;
  assign rf_wdata     = (w_cp0_op & ~w_cp0_we) ? w_cp0_rdata : w_result;
  assign ms_ex        = w_exc | w_eret;
  assign ex_target    = w_exc  ? ((w_tlb_refill & ~r_status_exl) ? REFILL_VECTOR : EX_VECTOR) :
                        w_eret ? r_epc : 32'd0;
  assign ms_cancel_in = w_tlb_op;
  assign refetch_pc   = w_tlb_op ? (w_pc + 32'd4) : 32'd0;
  assign tlbwi_we     = w_tlb_op & w_tlbwi;
  assign tlbr_re      = w_tlb_op & w_tlbr;
  assign int_pending  = r_status_ie & ~r_status_exl & (|(w_cause_ip & r_status_im));

  assign debug_wb_pc       = w_pc;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: per-instruction expectations go through a
// scoreboard queue; CP0 state is observed through MFC0 read-backs.
module tb_wb_stage;

  typedef struct packed {
    logic        tlb_refill;
    logic [3:0]  s1_index;
    logic        s1_found;
    logic        tlbp;
    logic        tlbr;
    logic        tlbwi;
    logic        eret;
    logic [31:0] badvaddr;
    logic        bd;
    logic        has_exc;
    logic [4:0]  exccode;
    logic        cp0_op;
    logic        cp0_we;
    logic [7:0]  cp0_addr;
    logic [1:0]  ls_offset;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } ms_bus_t;

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        ms_ex;
    logic [31:0] target;
    logic        cancel;
    logic [31:0] refetch;
    logic        tlbwi;
    logic        tlbr;
    logic [31:0] pc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         ws_allowin;
  logic         ms_to_ws_valid;
  logic [130:0] ms_to_ws_bus;
  logic [5:0]   ext_int;
  logic         rf_we;
  logic [4:0]   rf_waddr;
  logic [31:0]  rf_wdata;
  logic         ms_ex;
  logic [31:0]  ex_target;
  logic         ms_cancel_in;
  logic [31:0]  refetch_pc;
  logic         tlbwi_we;
  logic         tlbr_re;
  logic         int_pending;
  logic [31:0]  debug_wb_pc;
  logic [3:0]   debug_wb_rf_wen;
  logic [4:0]   debug_wb_rf_wnum;
  logic [31:0]  debug_wb_rf_wdata;

  wb_stage dut (
    .clk(clk), .reset(reset), .ws_allowin(ws_allowin),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus), .ext_int(ext_int),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ms_ex(ms_ex), .ex_target(ex_target), .ms_cancel_in(ms_cancel_in),
    .refetch_pc(refetch_pc), .tlbwi_we(tlbwi_we), .tlbr_re(tlbr_re),
    .int_pending(int_pending), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  int      n_tests = 0;
  int      n_fail  = 0;
  exp_t    sb[$];
  string   tq[$];
  logic [31:0] pcc = 32'h8000_0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic ms_bus_t b_alu(input logic [31:0] pc, input logic [4:0] dest, input logic [31:0] res);
    ms_bus_t b = '0;
    b.pc = pc; b.dest = dest; b.result = res; b.gr_we = 1'b1;
    return b;
  endfunction

  function automatic ms_bus_t b_mtc0(input logic [7:0] addr, input logic [31:0] val);
    ms_bus_t b = '0;
    b.pc = 32'h8000_0800; b.cp0_op = 1'b1; b.cp0_we = 1'b1; b.cp0_addr = addr; b.result = val;
    return b;
  endfunction

  function automatic ms_bus_t b_exc(input logic [31:0] pc, input logic [4:0] code, input logic bd,
                                    input logic [31:0] bva, input logic refill);
    ms_bus_t b = '0;
    b.pc = pc; b.exccode = code; b.bd = bd; b.badvaddr = bva; b.tlb_refill = refill;
    b.has_exc = 1'b1; b.gr_we = 1'b1; b.dest = 5'd9; b.result = 32'h5555_AAAA;
    return b;
  endfunction

  function automatic ms_bus_t b_ctl(input logic [31:0] pc, input logic eret, input logic wi, input logic r);
    ms_bus_t b = '0;
    b.pc = pc; b.eret = eret; b.tlbwi = wi; b.tlbr = r;
    return b;
  endfunction

  function automatic exp_t e_base(input logic [31:0] pc);
    exp_t e = '0;
    e.pc = pc;
    return e;
  endfunction

  // Drive one instruction, push its expectation, then pop and compare it.
  task automatic issue(input string tag, input ms_bus_t b, input exp_t e);
    exp_t x;
    string t;
    sb.push_back(e);
    tq.push_back(tag);
    @(negedge clk);
    ms_to_ws_bus   = b;
    ms_to_ws_valid = 1'b1;
    @(posedge clk);
    #1;
    ms_to_ws_valid = 1'b0;
    x = sb.pop_front();
    t = tq.pop_front();
    chk({t, ".rf_we"},  {31'd0, rf_we}, {31'd0, x.rf_we});
    chk({t, ".wen"},    {28'd0, debug_wb_rf_wen}, {28'd0, {4{x.rf_we}}});
    chk({t, ".pc"},     debug_wb_pc, x.pc);
    chk({t, ".ms_ex"},  {31'd0, ms_ex}, {31'd0, x.ms_ex});
    chk({t, ".cancel"}, {31'd0, ms_cancel_in}, {31'd0, x.cancel});
    chk({t, ".tlbwi"},  {31'd0, tlbwi_we}, {31'd0, x.tlbwi});
    chk({t, ".tlbr"},   {31'd0, tlbr_re}, {31'd0, x.tlbr});
    if (x.rf_we) begin
      chk({t, ".waddr"}, {27'd0, rf_waddr}, {27'd0, x.waddr});
      chk({t, ".wdata"}, rf_wdata, x.wdata);
      chk({t, ".wnum"},  {27'd0, debug_wb_rf_wnum}, {27'd0, x.waddr});
      chk({t, ".dwdata"}, debug_wb_rf_wdata, x.wdata);
    end
    if (x.ms_ex)  chk({t, ".target"}, ex_target, x.target);
    if (x.cancel) chk({t, ".refetch"}, refetch_pc, x.refetch);
  endtask

  task automatic wr_alu(input string tag, input logic [4:0] dest, input logic [31:0] val, input logic squashed);
    exp_t e = e_base(pcc);
    if (!squashed) begin
      e.rf_we = 1'b1; e.waddr = dest; e.wdata = val;
    end
    issue(tag, b_alu(pcc, dest, val), e);
    pcc = pcc + 32'd4;
  endtask

  task automatic mtc0(input string tag, input logic [7:0] addr, input logic [31:0] val);
    issue(tag, b_mtc0(addr, val), e_base(32'h8000_0800));
  endtask

  task automatic rd_cp0(input string tag, input logic [7:0] addr, input logic [31:0] exp);
    ms_bus_t b = '0;
    exp_t    e = e_base(pcc);
    b.pc = pcc; b.cp0_op = 1'b1; b.cp0_addr = addr; b.gr_we = 1'b1; b.dest = 5'd2;
    b.result = 32'hDEAD_BEEF;
    e.rf_we = 1'b1; e.waddr = 5'd2; e.wdata = exp;
    issue(tag, b, e);
    pcc = pcc + 32'd4;
  endtask

  task automatic flush(input string tag, input ms_bus_t b, input logic [31:0] target);
    exp_t e = e_base(b.pc);
    e.ms_ex = 1'b1; e.target = target;
    issue(tag, b, e);
  endtask

  task automatic tlbop(input string tag, input logic [31:0] pc, input logic wi);
    exp_t e = e_base(pc);
    e.cancel = 1'b1; e.refetch = pc + 32'd4; e.tlbwi = wi; e.tlbr = ~wi;
    issue(tag, b_ctl(pc, 1'b0, wi, ~wi), e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; ms_to_ws_valid = 1'b0; ms_to_ws_bus = '0; ext_int = 6'd0;
    idle(3);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst.rf_we",  {31'd0, rf_we}, 32'd0);
    chk("rst.ms_ex",  {31'd0, ms_ex}, 32'd0);
    chk("rst.cancel", {31'd0, ms_cancel_in}, 32'd0);
    chk("rst.intp",   {31'd0, int_pending}, 32'd0);
    chk("rst.wen",    {28'd0, debug_wb_rf_wen}, 32'd0);
    chk("rst.pc",     debug_wb_pc, 32'd0);
    chk("rst.allow",  {31'd0, ws_allowin}, 32'd1);

    pcc = 32'hBFC0_0000;
    wr_alu("addu", 5'd5, 32'h1234, 1'b0);

    // Timer: Compare=10, Count=0, TI must appear only after Count reaches 10
    mtc0("mtc0.cmp", 8'h58, 32'd10);
    mtc0("mtc0.cnt", 8'h48, 32'd0);
    idle(6);
    rd_cp0("cause.early", 8'h68, 32'h0000_0000);
    idle(20);
    rd_cp0("cause.ti", 8'h68, 32'h4000_8000);
    mtc0("mtc0.status", 8'h60, 32'h0040_8001);
    rd_cp0("status", 8'h60, 32'h0040_8001);
    chk("intp.timer", {31'd0, int_pending}, 32'd1);
    mtc0("mtc0.cmp2", 8'h58, 32'h0000_1000);
    rd_cp0("cause.ticlr", 8'h68, 32'h0000_0000);
    chk("intp.clr", {31'd0, int_pending}, 32'd0);
    mtc0("mtc0.cnt2", 8'h48, 32'h0000_0100);
    rd_cp0("count", 8'h48, 32'h0000_0100);
    rd_cp0("compare", 8'h58, 32'h0000_1000);
    rd_cp0("unmapped", 8'h50, 32'h0000_0000);

    // AdEL in a delay slot
    flush("adel", b_exc(32'hBFC0_0100, 5'd4, 1'b1, 32'h3, 1'b0), 32'hBFC0_0380);
    idle(1);
    rd_cp0("adel.epc", 8'h70, 32'hBFC0_00FC);
    rd_cp0("adel.cause", 8'h68, 32'h8000_0010);
    rd_cp0("adel.badv", 8'h40, 32'h0000_0003);
    rd_cp0("adel.status", 8'h60, 32'h0040_8003);

    // Refill while EXL=1 goes to the general vector and keeps EPC/BD
    flush("tlbl.exl1", b_exc(32'hBFC0_0200, 5'd2, 1'b0, 32'h1234_5000, 1'b1), 32'hBFC0_0380);
    idle(1);
    rd_cp0("tlbl1.epc", 8'h70, 32'hBFC0_00FC);
    rd_cp0("tlbl1.cause", 8'h68, 32'h8000_0008);
    rd_cp0("tlbl1.badv", 8'h40, 32'h1234_5000);

    flush("eret1", b_ctl(32'h8000_0300, 1'b1, 1'b0, 1'b0), 32'hBFC0_00FC);
    wr_alu("eret1.squash", 5'd6, 32'h66, 1'b1);
    rd_cp0("eret1.status", 8'h60, 32'h0040_8001);

    flush("tlbl.exl0", b_exc(32'h8000_0040, 5'd2, 1'b0, 32'h0040_0000, 1'b1), 32'hBFC0_0200);
    idle(1);
    rd_cp0("tlbl0.epc", 8'h70, 32'h8000_0040);
    rd_cp0("tlbl0.cause", 8'h68, 32'h0000_0008);

    flush("eret2", b_ctl(32'hBFC0_0380, 1'b1, 1'b0, 1'b0), 32'h8000_0040);
    wr_alu("eret2.squash", 5'd7, 32'h77, 1'b1);
    rd_cp0("eret2.status", 8'h60, 32'h0040_8001);

    // TLBWI refetch: the back-to-back instruction is dropped, the next commits
    tlbop("tlbwi", 32'h8000_1000, 1'b1);
    wr_alu("tlbwi.drop", 5'd8, 32'h88, 1'b1);
    wr_alu("tlbwi.next", 5'd8, 32'h99, 1'b0);
    tlbop("tlbr", 32'h8000_2000, 1'b0);
    idle(1);

    ext_int = 6'b10_0000;
    rd_cp0("cause.ext", 8'h68, 32'h0000_8008);
    chk("intp.ext", {31'd0, int_pending}, 32'd1);
    ext_int = 6'd0;

    // Reset on the same edge the exception would commit
    flush("rst.exc", b_exc(32'h8000_3000, 5'd10, 1'b0, 32'h0, 1'b0), 32'hBFC0_0380);
    reset = 1'b1;
    idle(1);
    chk("midrst.ms_ex",  {31'd0, ms_ex}, 32'd0);
    chk("midrst.rf_we",  {31'd0, rf_we}, 32'd0);
    chk("midrst.cancel", {31'd0, ms_cancel_in}, 32'd0);
    chk("midrst.intp",   {31'd0, int_pending}, 32'd0);
    reset = 1'b0;
    rd_cp0("midrst.status", 8'h60, 32'h0040_0000);
    rd_cp0("midrst.epc", 8'h70, 32'h0000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Final (5th) pipeline stage. Accepts the memory stage's result bus and commits register-file writes.
- Owns a CP0 subset: BadVAddr, Count, Compare, Status, Cause, EPC.
- Resolves exceptions and ERET into a one-cycle pipeline flush with redirect PC.
- Issues the TLBR/TLBWI refetch cancel, and drives the debug trace and interrupt-pending outputs.

Parameters:
- MS_TO_WS_BUS_WD, 131, width of incoming memory-stage bus.
- EX_VECTOR, 32'hBFC00380, general exception entry.
- REFILL_VECTOR, 32'hBFC00200, TLB refill entry when Status.EXL=0.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- ws_allowin  out  1  stage can accept.
- ms_to_ws_valid  in  1  upstream valid.
- ms_to_ws_bus  in  131  bit fields:
  - [130] tlb_refill; [129:126] s1_index; [125] s1_found; [124] tlbp; [123] tlbr; [122] tlbwi; [121] eret.
  - [120:89] badvaddr; [88] bd; [87] has_exc; [86:82] exccode; [81] cp0_op; [80] cp0_we; [79:72] cp0_addr.
  - [71:70] ls_offset; [69] gr_we; [68:64] dest; [63:32] result; [31:0] pc.
- ext_int  in  6  hardware interrupt lines → Cause.IP[7:2].
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  write address.
- rf_wdata  out  32  write data.
- ms_ex  out  1  flush pulse (exception or ERET).
- ex_target  out  32  redirect PC, valid with ms_ex.
- ms_cancel_in  out  1  TLBR/TLBWI refetch pulse.
- refetch_pc  out  32  pc+4 of the TLB instruction.
- tlbwi_we  out  1  write-TLB strobe.
- tlbr_re  out  1  read-TLB strobe.
- int_pending  out  1  interrupt request to decode.
- debug_wb_pc  out  32  committed PC.
- debug_wb_rf_wen  out  4  replicated rf_we.
- debug_wb_rf_wnum  out  5  = rf_waddr.
- debug_wb_rf_wdata  out  32  = rf_wdata.

Behaviour:
- Handshake:
  - ws_ready_go = 1; ws_allowin = 1 always.
  - Bus is latched when ms_to_ws_valid & ws_allowin.
  - ws_valid <= ms_to_ws_valid each cycle, except it is cleared the cycle after ms_ex or ms_cancel_in.
  - Reset: ws_valid = 0.
- Commit (all combinational from ws_valid and latched bus):
  - rf_we = ws_valid & gr_we & ~has_exc.
  - rf_wdata = CP0 read value when cp0_op & ~cp0_we (MFC0); otherwise result.
- CP0 address = {rd[4:0], sel[2:0]}: BadVAddr 0x40, Count 0x48, Compare 0x58, Status 0x60, Cause 0x68, EPC 0x70. Unmapped addresses read 0; writes to them are ignored.
- MTC0 (cp0_we & ws_valid & ~has_exc) writes result; writable bits:
  - Status: IM[15:8], EXL[1], IE[0]; bit 22 (BEV) reads 1.
  - Cause: IP[9:8].
  - Count: all bits.
  - Compare: all bits; the write also clears Cause.TI.
- Reset values: Status = 32'h0040_0000; Cause = 0; Count = 0; Compare = 0; EPC = 0; BadVAddr = 0.
- Count:
  - A tick flop toggles every cycle; Count increments when tick = 1 (every 2nd cycle).
  - An MTC0 to Count has priority over the increment.
- Timer: Cause.TI (bit 30) sets when Count == Compare (and not an MTC0-Compare cycle); it stays set until Compare is written. Cause.IP[7] = ext_int[5] | TI.
- int_pending = Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0]).
- Exception, when ws_valid & has_exc:
  - ms_ex = 1; Cause.ExcCode = exccode; Status.EXL = 1.
  - If EXL was 0: EPC = bd ? pc-4 : pc, and Cause.BD = bd. If EXL was 1: EPC and BD are unchanged.
  - BadVAddr = badvaddr for exccode 4/5/2/3 (AdEL/AdES/TLBL/TLBS).
  - ex_target = (tlb_refill & ~old EXL) ? REFILL_VECTOR : EX_VECTOR.
  - rf_we = 0.
- ERET, when ws_valid & eret & ~has_exc: ms_ex = 1, ex_target = EPC, EXL cleared.
- Exception beats ERET when both are set.
- TLBWI/TLBR, when ws_valid & ~has_exc: tlbwi_we or tlbr_re = 1 and ms_cancel_in = 1 for one cycle; refetch_pc = pc+4.
- tlbp is a pass-through: Index is held outside this block.
- Pulses: ms_ex and ms_cancel_in each last exactly one cycle per instruction; the next-cycle ws_valid clear guarantees this.
- Reset mid-operation: pending flush is dropped, all registers return to reset values, and all outputs are 0 except Status.BEV.

Test Plan:
- Reset, then ADDU commit with dest=5, result=32'h1234 → rf_we=1, waddr=5, wdata=32'h1234, debug_wb_rf_wen=4'hF, debug_wb_pc=pc.
- MTC0 Compare=10 with Count=0, run 20 cycles → TI=1 at Count==10. With Status=32'h0040_8001, int_pending=1. MTC0 Compare clears TI.
- AdEL (exccode 4) at pc=32'hBFC0_0100, bd=1, badvaddr=32'h3 → ms_ex pulse, EPC=32'hBFC0_00FC, Cause.BD=1, ExcCode=4, BadVAddr=3, ex_target=32'hBFC0_0380, rf_we=0.
- TLBL with tlb_refill=1: EXL=0 → ex_target=32'hBFC0_0200. Repeat with EXL=1 → 32'hBFC0_0380, EPC unchanged.
- ERET with EPC=32'h8000_0040 → ms_ex=1, ex_target=32'h8000_0040, EXL cleared. Next-cycle instruction is squashed.
- TLBWI at pc=32'h8000_1000 → tlbwi_we=1, ms_cancel_in one cycle, refetch_pc=32'h8000_1004. Back-to-back valid input is dropped for one cycle.
